// File: rtl/bus_rw_master.sv
// Single-outstanding bus master: takes one read/write command, arbitrates for the
// bus, runs the transfer with a bounded rdy wait, and returns one response.
module bus_rw_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MODE_W  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [MODE_W-1:0] cmd_mode,
  output logic              req,
  input  logic              gnt,
  output logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [MODE_W-1:0] mode,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rdy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, START, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lat_write_q, lat_write_d;
  logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]  lat_wdata_q, lat_wdata_d;
  logic [MODE_W-1:0]  lat_mode_q, lat_mode_d;

  logic               cmd_ready_d, req_d, start_d, we_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [MODE_W-1:0]  mode_d;
  logic [DATA_W-1:0]  wdata_d, rsp_rdata_d;
  logic               bus_active;

  // State, timeout counter and latched command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_mode_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_mode_q  <= lat_mode_d;
    end
  end

  // Next state, plus next output values decoded from the next state so every
  // output is a flop that lines up with the state it belongs to
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_mode_d  = lat_mode_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          lat_write_d = cmd_write;
          lat_addr_d  = cmd_addr;
          lat_wdata_d = cmd_wdata;
          lat_mode_d  = cmd_mode;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (gnt) state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // rdy takes priority over a timeout firing on the same cycle
        if (rdy) begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = lat_write_q ? '0 : rdata;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    bus_active  = (state_d == START) || (state_d == WAIT);
    cmd_ready_d = (state_d == IDLE);
    req_d       = (state_d == REQ) || bus_active;
    start_d     = (state_d == START);
    rsp_valid_d = (state_d == RESP);
    addr_d      = bus_active ? lat_addr_d  : '0;
    mode_d      = bus_active ? lat_mode_d  : '0;
    we_d        = bus_active ? lat_write_d : 1'b0;
    wdata_d     = bus_active ? lat_wdata_d : '0;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      req       <= 1'b0;
      start     <= 1'b0;
      addr      <= '0;
      mode      <= '0;
      we        <= 1'b0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      req       <= req_d;
      start     <= start_d;
      addr      <= addr_d;
      mode      <= mode_d;
      we        <= we_d;
      wdata     <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_bus_rw_master.sv
// Directed bench for bus_rw_master: table of full transactions plus hand-written
// reset and back-to-back sequences. Inputs change and outputs are sampled on negedge.
module tb_bus_rw_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [1:0] cmd_mode;
  logic       req, gnt, start, we;
  logic [7:0] addr, wdata, rdata;
  logic [1:0] mode;
  logic       rdy, rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_rw_master #(.ADDR_W(8), .DATA_W(8), .MODE_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mode(cmd_mode),
    .req(req), .gnt(gnt), .start(start), .addr(addr), .mode(mode),
    .we(we), .wdata(wdata), .rdata(rdata), .rdy(rdy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] mode;
    int         gnt_dly;    // REQ cycles with gnt low before grant
    int         rdy_at;     // WAIT cycle index (0-based) where rdy rises; -1 = never
    logic [7:0] rdata;
    int         hold;       // RESP cycles with rsp_ready low
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_wait;   // number of WAIT cycles expected
  } vec_t;

  vec_t vecs[7];

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string nm);
    logic [31:0] act;
    act = {8'd0, cmd_ready, req, start, we, mode, addr, wdata, rsp_valid, rsp_err};
    check({cmd_ready, req, start, we, mode, addr, wdata, rsp_valid, rsp_err} == 24'h80_0000,
          nm, act, 32'h0080_0000);
  endtask

  // Run one transaction; called and returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string nm);
    int w;
    logic [20:0] bus_exp;
    logic [20:0] rsp_exp;
    check(cmd_ready == 1'b1, {nm, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_mode = v.mode; rdata = v.rdata;
    gnt = (v.gnt_dly == 0); rdy = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00; cmd_write = 1'b0;
    for (int i = 0; i < v.gnt_dly; i++) begin
      check(req && !start && !cmd_ready && addr == 8'h00, {nm, "_req_hold"},
            {28'd0, req, start, cmd_ready, 1'b0}, 32'h8);
      gnt = 1'b0;
      @(negedge clk);
    end
    check(req && !start && addr == 8'h00, {nm, "_req_last"}, {30'd0, req, start}, 32'h2);
    gnt = 1'b1;
    @(negedge clk);
    bus_exp = {1'b1, 1'b1, v.wr, v.mode, v.addr, v.wdata};
    check({req, start, we, mode, addr, wdata} == bus_exp, {nm, "_start"},
          32'({req, start, we, mode, addr, wdata}), 32'(bus_exp));
    gnt = 1'b1; rdy = 1'b1;
    @(negedge clk);
    bus_exp[19] = 1'b0;
    w = 0;
    while (!rsp_valid && w < 100) begin
      if (w < 18)
        check({req, start, we, mode, addr, wdata} == bus_exp, {nm, "_wait_bus"},
              32'({req, start, we, mode, addr, wdata}), 32'(bus_exp));
      rdy = (w == v.rdy_at);
      w++;
      @(negedge clk);
    end
    rdy = 1'b0; gnt = 1'b1;
    check(w == v.exp_wait, {nm, "_wait_cycles"}, 32'(w), 32'(v.exp_wait));
    rsp_exp = {1'b1, 1'b0, 1'b0, v.exp_err, v.exp_rdata, 9'd0};
    check({rsp_valid, req, cmd_ready, rsp_err, rsp_rdata, addr, we} == rsp_exp,
          {nm, "_rsp"}, 32'({rsp_valid, req, cmd_ready, rsp_err, rsp_rdata, addr, we}),
          32'(rsp_exp));
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check({rsp_valid, cmd_ready, rsp_err, rsp_rdata} ==
            {1'b1, 1'b0, v.exp_err, v.exp_rdata}, {nm, "_rsp_hold"},
            32'({rsp_valid, cmd_ready, rsp_err, rsp_rdata}),
            32'({1'b1, 1'b0, v.exp_err, v.exp_rdata}));
    end
    // cmd_valid high on the releasing edge must not be accepted
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0; gnt = 1'b0;
    check_idle({nm, "_done"});
    @(negedge clk);
    check_idle({nm, "_no_accept"});
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'hC3, 2'd1, 0, 0,  8'hA5, 0,  8'hA5, 1'b0, 1};
    vecs[1] = '{1'b1, 8'h10, 8'h5A, 2'd2, 5, 2,  8'h99, 1,  8'h00, 1'b0, 3};
    vecs[2] = '{1'b0, 8'h44, 8'h11, 2'd3, 1, -1, 8'h66, 0,  8'h00, 1'b1, 16};
    vecs[3] = '{1'b0, 8'h81, 8'h00, 2'd0, 0, 15, 8'h77, 0,  8'h77, 1'b0, 16};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 2'd0, 2, 3,  8'h3E, 10, 8'h3E, 1'b0, 4};
    vecs[5] = '{1'b1, 8'h07, 8'hE1, 2'd1, 0, -1, 8'hF0, 2,  8'h00, 1'b1, 16};
    vecs[6] = '{1'b1, 8'h2B, 8'hB2, 2'd3, 3, 14, 8'h5D, 0,  8'h00, 1'b0, 15};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_mode = '0; gnt = 1'b0; rdata = '0; rdy = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_state");
    check(rsp_rdata == 8'h00, "reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset pulsed in the middle of WAIT
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h5C; cmd_wdata = 8'h33;
    cmd_mode = 2'd2; gnt = 1'b1; rdy = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check({req, start, addr} == {1'b1, 1'b0, 8'h5C}, "mid_wait_bus",
          32'({req, start, addr}), 32'h25C);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    rdy = 1'b1; rdata = 8'hEE;
    @(negedge clk);
    check_idle("reset_held");
    rst_n = 1'b1;
    run_vec(vecs[0], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
